// File: rtl/pl_pkg.sv
// Shared types and constants for the pipeline stage register.
// Holds the skid FSM encoding, default field widths and ID/EX control-bit positions.
package pl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pl_state_e;

  localparam int unsigned PL_CW = 16;
  localparam int unsigned PL_DW = 160;

  // ID/EX control-field layout
  localparam int unsigned IDEX_REGWRITE     = 0;
  localparam int unsigned IDEX_MEMWRITE     = 1;
  localparam int unsigned IDEX_BRANCH       = 2;
  localparam int unsigned IDEX_JUMP         = 3;
  localparam int unsigned IDEX_JALR         = 4;
  localparam int unsigned IDEX_RESULTSRC_LO = 5;
  localparam int unsigned IDEX_RESULTSRC_HI = 6;
  localparam int unsigned IDEX_ALUSRC       = 7;
  localparam int unsigned IDEX_ALUCTRL_LO   = 8;
  localparam int unsigned IDEX_ALUCTRL_HI   = 11;
  localparam int unsigned IDEX_LAUISEL      = 12;

endpackage

// File: rtl/pl_entry.sv
// One valid+ctrl+data holding register; priority is clear > load > drop.
// Ctrl is zeroed on clear; data is zeroed on clear only when CLEAR_DATA != 0.
module pl_entry
  import pl_pkg::*;
#(
  parameter int unsigned CW         = PL_CW,
  parameter int unsigned DW         = PL_DW,
  parameter int unsigned CLEAR_DATA = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_drop,
  input  logic [CW-1:0] i_ctrl,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [CW-1:0] o_ctrl,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [CW-1:0] r_ctrl;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLEAR_DATA != 0) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pl_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and flush counter.
// Define PL_STAGE_SKID_EN to add a skid entry that makes in_ready a registered signal.
module pl_stage_reg
  import pl_pkg::*;
#(
  parameter int unsigned CW         = PL_CW,
  parameter int unsigned DW         = PL_DW,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNTW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_ctrl,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ctrl,
  output logic [DW-1:0]   out_data,
  output logic [CNTW-1:0] flush_cnt
);

  logic            w_m_valid;
  logic [CW-1:0]   w_m_ctrl;
  logic [DW-1:0]   w_m_data;
  logic            w_m_load;
  logic            w_m_drop;
  logic [CW-1:0]   w_m_ld_ctrl;
  logic [DW-1:0]   w_m_ld_data;
  logic            w_accept;
  logic            w_deliver;
  logic            w_any_valid;
  logic [CNTW-1:0] r_flush_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = w_m_valid & out_ready;

`ifdef PL_STAGE_SKID_EN
  pl_state_e     r_state;
  pl_state_e     w_state_nxt;
  logic          r_in_ready;
  logic          w_s_valid;
  logic [CW-1:0] w_s_ctrl;
  logic [DW-1:0] w_s_data;
  logic          w_s_load;
  logic          w_s_drop;
  logic          w_m_src_s;

  assign in_ready    = clr | r_in_ready;
  assign w_any_valid = w_m_valid | w_s_valid;
  assign w_m_ld_ctrl = w_m_src_s ? w_s_ctrl : in_ctrl;
  assign w_m_ld_data = w_m_src_s ? w_s_data : in_data;

  always_comb begin
    w_state_nxt = r_state;
    w_m_load    = 1'b0;
    w_m_drop    = 1'b0;
    w_m_src_s   = 1'b0;
    w_s_load    = 1'b0;
    w_s_drop    = 1'b0;
    if (clr) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_m_load    = 1'b1;
          w_state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_m_load = 1'b1;
          end else if (w_accept) begin
            w_s_load    = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_deliver) begin
            w_m_drop    = 1'b1;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (w_deliver) begin
          // S advances into M so beat order is preserved
          w_m_load    = 1'b1;
          w_m_src_s   = 1'b1;
          w_s_drop    = 1'b1;
          w_state_nxt = ST_ONE;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  pl_entry #(.CW(CW), .DW(DW), .CLEAR_DATA(CLEAR_DATA)) u_s (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_load  (w_s_load),
    .i_drop  (w_s_drop),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_s_valid),
    .o_ctrl  (w_s_ctrl),
    .o_data  (w_s_data)
  );
`else
  assign in_ready    = clr | ~w_m_valid | out_ready;
  assign w_any_valid = w_m_valid;
  assign w_m_ld_ctrl = in_ctrl;
  assign w_m_ld_data = in_data;
  assign w_m_load    = w_accept;
  assign w_m_drop    = w_deliver & ~w_accept;
`endif

  pl_entry #(.CW(CW), .DW(DW), .CLEAR_DATA(CLEAR_DATA)) u_m (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_load  (w_m_load),
    .i_drop  (w_m_drop),
    .i_ctrl  (w_m_ld_ctrl),
    .i_data  (w_m_ld_data),
    .o_valid (w_m_valid),
    .o_ctrl  (w_m_ctrl),
    .o_data  (w_m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (clr && w_any_valid && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + CNTW'(1);
    end
  end

  assign out_valid = w_m_valid;
  assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
  assign out_data  = w_m_data;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pl_stage_reg.sv
// Scoreboard bench for pl_stage_reg: expected beats are queued at issue time and
// popped by an independent monitor; a second instance covers CLEAR_DATA=0 and CNTW=2.
module tb_pl_stage_reg;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_ctrl = '0;
  logic [159:0]  in_data = '0;
  logic          out_ready = 1'b1;

  logic          in_ready, out_valid;
  logic [15:0]   out_ctrl;
  logic [159:0]  out_data;
  logic [15:0]   flush_cnt;

  logic          in_ready2, out_valid2;
  logic [15:0]   out_ctrl2;
  logic [159:0]  out_data2;
  logic [1:0]    flush_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0]  ctrl;
    logic [159:0] data;
    int           due;
  } exp_t;
  exp_t q[$];

  pl_stage_reg #(.CW(16), .DW(160), .CLEAR_DATA(1), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .flush_cnt(flush_cnt)
  );

  pl_stage_reg #(.CW(16), .DW(160), .CLEAR_DATA(0), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2), .flush_cnt(flush_cnt2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = 160'(d);
  endtask

  task automatic push(input logic [15:0] c, input logic [31:0] d, input int due);
    exp_t e;
    e.ctrl = c;
    e.data = 160'(d);
    e.due  = due;
    q.push_back(e);
  endtask

  // Monitor: a beat is delivered at the coming edge when valid && ready and no flush
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && !clr && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_beat: got %0h expected none", out_data);
      end else begin
        e = q.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_ctrl", 160'(out_ctrl), 160'(e.ctrl));
        if (e.due >= 0) check("sb_latency", 160'(cyc), 160'(e.due));
      end
    end
  end

  initial begin
    // Reset with live-looking input
    drive(1'b1, 16'hFFFF, 32'hDEAD_BEEF);
    repeat (2) step();
    @(negedge clk);
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_out_ctrl", 160'(out_ctrl), 160'(0));
    check("rst_out_data", out_data, 160'(0));
    check("rst_flush_cnt", 160'(flush_cnt), 160'(0));
    check("rst_out_data2", out_data2, 160'(0));
    step();
    drive(1'b0, 16'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 160'(in_ready), 160'(1));
    check("rel_in_ready2", 160'(in_ready2), 160'(1));
    step();

    // Streaming: one beat per cycle, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(i + 1), 32'h100 + 32'(i));
      push(16'(i + 1), 32'h100 + 32'(i), cyc + 1);
      @(negedge clk);
      check("stream_in_ready", 160'(in_ready), 160'(1));
      step();
    end
    drive(1'b0, 16'h0, 32'h0);
    repeat (2) step();

    // Stall: A held, B waits (or lands in skid)
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 32'hAAAA);
    push(16'h0011, 32'hAAAA, -1);
    step();
    drive(1'b1, 16'h0022, 32'hBBBB);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", 160'(out_valid), 160'(1));
      check("stall_out_data", out_data, 160'(32'hAAAA));
      check("stall_out_ctrl", 160'(out_ctrl), 160'(16'h0011));
`ifdef PL_STAGE_SKID_EN
      check("stall_in_ready", 160'(in_ready), 160'((k == 0) ? 1 : 0));
      if (k == 0) push(16'h0022, 32'hBBBB, -1);
      step();
      if (k == 0) drive(1'b0, 16'h0, 32'h0);
`else
      check("stall_in_ready", 160'(in_ready), 160'(0));
      step();
`endif
    end
    out_ready = 1'b1;
`ifndef PL_STAGE_SKID_EN
    push(16'h0022, 32'hBBBB, -1);
    step();
    drive(1'b0, 16'h0, 32'h0);
`endif
    repeat (3) step();

    // Flush with a valid entry and a beat on offer during clr
    out_ready = 1'b0;
    drive(1'b1, 16'h00FF, 32'hC0DE);
    step();
    clr = 1'b1;
    drive(1'b1, 16'h0033, 32'hDEAD);
    @(negedge clk);
    check("flush_in_ready", 160'(in_ready), 160'(1));
    step();
    clr = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h0044, 32'h5555);
    push(16'h0044, 32'h5555, cyc + 1);
    @(negedge clk);
    check("flush_out_valid", 160'(out_valid), 160'(0));
    check("flush_out_ctrl", 160'(out_ctrl), 160'(0));
    check("flush_out_data", out_data, 160'(0));
    check("flush_cnt_1", 160'(flush_cnt), 160'(1));
    check("flush_out_valid2", 160'(out_valid2), 160'(0));
    check("flush_out_ctrl2", 160'(out_ctrl2), 160'(0));
    check("flush_keep_data2", out_data2, 160'(32'hC0DE));
    check("flush_cnt2_1", 160'(flush_cnt2), 160'(1));
    step();
    drive(1'b0, 16'h0, 32'h0);
    repeat (2) step();

    // Idle flush leaves the counter alone
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    check("idle_flush_cnt", 160'(flush_cnt), 160'(1));
    check("idle_flush_cnt2", 160'(flush_cnt2), 160'(1));
    step();

    // Three more valid flushes: 16-bit counter reaches 4, 2-bit saturates at 3
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 16'h0007, 32'h7000 + 32'(r));
      step();
      drive(1'b0, 16'h0, 32'h0);
      clr = 1'b1;
      step();
      clr = 1'b0;
    end
    @(negedge clk);
    check("sat_flush_cnt", 160'(flush_cnt), 160'(4));
    check("sat_flush_cnt2", 160'(flush_cnt2), 160'(3));
    step();

    // Asynchronous reset mid-stall (TWO state when skid is present)
    out_ready = 1'b0;
    drive(1'b1, 16'h000F, 32'h9999);
    step();
    drive(1'b1, 16'h00F0, 32'h8888);
    step();
    drive(1'b0, 16'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 160'(out_valid), 160'(0));
    check("arst_out_ctrl", 160'(out_ctrl), 160'(0));
    check("arst_out_data", out_data, 160'(0));
    check("arst_flush_cnt", 160'(flush_cnt), 160'(0));
    check("arst_flush_cnt2", 160'(flush_cnt2), 160'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_in_ready", 160'(in_ready), 160'(1));
    check("arst_rel_out_valid", 160'(out_valid), 160'(0));
    step();
    out_ready = 1'b1;
    drive(1'b1, 16'h0005, 32'h1234);
    push(16'h0005, 32'h1234, cyc + 1);
    step();
    drive(1'b0, 16'h0, 32'h0);

    for (int w = 0; w < 20 && q.size() > 0; w++) step();
    check("sb_drained", 160'(q.size()), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pl_stage_reg.md
# pl_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and stall. It replaces the fixed per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block instantiated at every stage boundary. Payload is split into a control field, which is zeroed on a flush to form a bubble, and a data field. An optional skid slot breaks the combinational ready path.

## Interface
Parameters:
- CW, 16: control-field width (RegWrite, MemWrite, Branch, Jump, ResultSrc, …), zeroed on flush and reset.
- DW, 160: data-field width (RD1, RD2, PC, PCPlus4, ImmExt, Rs1/Rs2/Rd, …).
- CLEAR_DATA, 1: 1 = zero the data field on reset and flush; 0 = data field holds its value.
- CNTW, 16: width of the flush counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- clr  in  1  synchronous flush, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CW  upstream control field.
- in_data  in  DW  upstream data field.
- out_valid  out  1  held beat valid.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CW  held control; all zeros whenever out_valid=0.
- out_data  out  DW  held data.
- flush_cnt  out  CNTW  saturating count of flushes that discarded at least one valid entry.

## Operation
- Handshakes:
  - Accept: in_valid && in_ready at a rising edge.
  - Deliver: out_valid && out_ready at a rising edge.
- Main entry M (valid, ctrl, data). Without skid, in_ready = !M.valid || out_ready, a combinational path.
- Simultaneous deliver and accept: M is replaced by the new beat, giving full throughput.
- Stall (out_ready=0, M.valid=1): M, out_ctrl and out_data hold bit-exact.
- Flush (clr=1):
  - Next edge: all entries become invalid, ctrl is zeroed, and data is zeroed if CLEAR_DATA=1.
  - clr has priority over every handshake.
  - in_ready is forced to 1 during clr. Any beat offered in that cycle is consumed and discarded.
- Output masking: out_ctrl = M.valid ? M.ctrl : 0. A bubble never carries live control bits.
- flush_cnt:
  - Increments by 1 on a clr edge where any entry was valid.
  - Saturates at 2^CNTW−1.
  - Cleared only by rst.
- Reset (rst=1, at any time including mid-stall): out_valid=0, out_ctrl=0, out_data=0, flush_cnt=0, skid empty. in_ready=1 once rst deasserts.

## Timing
- Latency: an accepted beat appears on out_* at the edge of acceptance, i.e. 1 cycle.
- Throughput is 1 beat/cycle when out_ready=1.
- clr asserted at edge N: out_valid=0 in cycle N+1. A beat offered in cycle N+1 appears at N+2.
- rst is asynchronous: outputs drop immediately. Release is synchronous to clk at the first edge with rst=0.
- Simultaneous clr and rst: rst wins and flush_cnt stays 0.

## Configuration
- Macro: PL_STAGE_SKID_EN.
- Defined: a second entry S (skid) is added, and in_ready = !S.valid, driven from a register with no path from out_ready.
  - States: EMPTY (M, S invalid), ONE (M valid), TWO (M and S valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without deliver; the incoming beat goes to S.
  - TWO→ONE on deliver; S moves to M. No accept is possible in TWO.
  - ONE→EMPTY on deliver without accept.
  - clr→EMPTY from any state.
  - Beat order is preserved.
- Undefined: single entry and combinational in_ready as in Operation. There is no TWO state. Area is one register set.

## Structure
- Package pl_pkg holds:
  - The skid state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2).
  - Default widths PL_CW=16, PL_DW=160.
  - Per-boundary control-field bit positions (ID/EX: RegWrite bit 0, MemWrite bit 1, Branch bit 2, Jump bit 3, Jalr bit 4, ResultSrc bits 6:5, ALUSrc bit 7, ALUControl bits 11:8, lauiSel bit 12).
- Sub-module pl_entry: one valid+ctrl+data register with load, clear and CLEAR_DATA behaviour. It is instantiated once for M and, under PL_STAGE_SKID_EN, once more for S.

## Test plan
- Reset:
  - Drive in_valid=1 and in_ctrl=16'hFFFF during rst → out_valid=0, out_ctrl=0, out_data=0, flush_cnt=0.
  - After release, in_ready=1.
- Streaming: out_ready=1, beats D0..D9 (data=32'h100+i) on consecutive cycles → out_data equals D(i) exactly 1 cycle after acceptance. No gaps.
- Stall:
  - Accept A=0xAAAA, then out_ready=0 for 5 cycles → out_data=0xAAAA held each cycle.
  - Without skid: in_ready=0. With skid: one extra beat B is accepted, then in_ready=0. After release, A then B is delivered.
- Flush:
  - Assert clr while M is valid with ctrl=16'h00FF and in_valid=1 → next cycle out_valid=0, out_ctrl=0, flush_cnt=1, and the offered beat is discarded.
  - With CLEAR_DATA=0, out_data keeps its previous value.
- Idle flush and saturation:
  - clr with all entries empty → flush_cnt unchanged.
  - With CNTW=2, four valid flushes → flush_cnt stays at 3.
- Async reset mid-stall: assert rst between clock edges in the TWO state → outputs clear immediately, and the state is EMPTY after release.
